// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: round-robin between the ALU and a small LSU result FIFO,
// registered y1/y2 outputs. Optional grant/stall counters under WB_PERF_CNT_EN.
module wb_port_arbiter #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          alu_valid,
    output logic          alu_ready,
    input  logic [3:0]    alu_y1_ch,
    input  logic [31:0]   alu_y1_data,
    input  logic [1:0]    alu_y2_ch,
    input  logic [31:0]   alu_y2_data,
    input  logic          mem_valid,
    output logic          mem_ready,
    input  logic [3:0]    mem_y1_ch,
    input  logic [31:0]   mem_y1_data,
    output logic [3:0]    wb_y1_channel,
    output logic [31:0]   wb_y1_data,
    output logic [1:0]    wb_y2_channel,
    output logic [31:0]   wb_y2_data,
    output logic [AW:0]   fifo_count
`ifdef WB_PERF_CNT_EN
    ,
    output logic [15:0]   perf_alu_grants,
    output logic [15:0]   perf_mem_grants,
    output logic [15:0]   perf_mem_full
`endif
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [3:0]    ch_mem  [DEPTH];
    logic [31:0]   dat_mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          rr_last;
    logic          blocked, empty, full, grant_alu, grant_mem, enq;

    // rr_last = 1 means MEM was granted last, so ALU wins the next tie.
    always_comb begin
        blocked   = rst | flush;
        empty     = (fifo_count == '0);
        full      = (fifo_count == FULL_CNT);
        grant_alu = !blocked && alu_valid && (empty || rr_last);
        grant_mem = !blocked && !empty && (!alu_valid || !rr_last);
        mem_ready = !blocked && !full;
        alu_ready = grant_alu;
        enq       = mem_valid && mem_ready;
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            ch_mem[wr_ptr]  <= mem_y1_ch;
            dat_mem[wr_ptr] <= mem_y1_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_count    <= '0;
            rr_last       <= 1'b1;
            wb_y1_channel <= '0;
            wb_y1_data    <= '0;
            wb_y2_channel <= '0;
            wb_y2_data    <= '0;
        end else begin
            if (enq)
                wr_ptr <= wr_ptr + 1'b1;
            if (grant_mem)
                rd_ptr <= rd_ptr + 1'b1;
            case ({enq, grant_mem})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase

            if (grant_alu) begin
                wb_y1_channel <= alu_y1_ch;
                wb_y1_data    <= alu_y1_data;
                wb_y2_channel <= alu_y2_ch;
                wb_y2_data    <= alu_y2_data;
                rr_last       <= 1'b0;
            end else if (grant_mem) begin
                wb_y1_channel <= ch_mem[rd_ptr];
                wb_y1_data    <= dat_mem[rd_ptr];
                wb_y2_channel <= '0;
                wb_y2_data    <= '0;
                rr_last       <= 1'b1;
            end else begin
                // Idle cycle: channel 0 makes the decoder do nothing.
                wb_y1_channel <= '0;
                wb_y1_data    <= '0;
                wb_y2_channel <= '0;
                wb_y2_data    <= '0;
            end
        end
    end

`ifdef WB_PERF_CNT_EN
    // Counters survive flush so a flush-heavy stretch is still visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_alu_grants <= '0;
            perf_mem_grants <= '0;
            perf_mem_full   <= '0;
        end else begin
            if (grant_alu && perf_alu_grants != 16'hFFFF)
                perf_alu_grants <= perf_alu_grants + 1'b1;
            if (grant_mem && perf_mem_grants != 16'hFFFF)
                perf_mem_grants <= perf_mem_grants + 1'b1;
            if (mem_valid && !mem_ready && perf_mem_full != 16'hFFFF)
                perf_mem_full <= perf_mem_full + 1'b1;
        end
    end
`else
    // Counters compiled out; arbitration is unaffected.
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios plus randomized traffic checked
// against a queue-based reference model of the arbiter.
module tb_wb_port_arbiter;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, flush, alu_valid, alu_ready, mem_valid, mem_ready;
    logic [3:0]    alu_y1_ch, mem_y1_ch, wb_y1_channel;
    logic [31:0]   alu_y1_data, alu_y2_data, mem_y1_data, wb_y1_data, wb_y2_data;
    logic [1:0]    alu_y2_ch, wb_y2_channel;
    logic [AW:0]   fifo_count;

    wb_port_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .alu_valid(alu_valid), .alu_ready(alu_ready),
        .alu_y1_ch(alu_y1_ch), .alu_y1_data(alu_y1_data),
        .alu_y2_ch(alu_y2_ch), .alu_y2_data(alu_y2_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_y1_ch(mem_y1_ch), .mem_y1_data(mem_y1_data),
        .wb_y1_channel(wb_y1_channel), .wb_y1_data(wb_y1_data),
        .wb_y2_channel(wb_y2_channel), .wb_y2_data(wb_y2_data),
        .fifo_count(fifo_count)
    );

    typedef struct packed { logic [3:0] ch; logic [31:0] d; } ent_t;

    // Reference model: LSU queue, who was granted last, expected output register.
    ent_t        q[$];
    bit          last_was_mem = 1'b1;
    logic [3:0]  e_y1c = '0;
    logic [31:0] e_y1d = '0, e_y2d = '0;
    logic [1:0]  e_y2c = '0;
    int          n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at negedge: drive, check combinational readies, clock, check registers.
    task automatic step(input bit r, input bit f, input bit av,
                        input logic [3:0] a1c, input logic [31:0] a1d,
                        input logic [1:0] a2c, input logic [31:0] a2d,
                        input bit mv, input logic [3:0] mc, input logic [31:0] md,
                        output bit ga, output bit acc);
        bit   gm, mr;
        ent_t h;
        rst = r; flush = f; alu_valid = av;
        alu_y1_ch = a1c; alu_y1_data = a1d; alu_y2_ch = a2c; alu_y2_data = a2d;
        mem_valid = mv; mem_y1_ch = mc; mem_y1_data = md;
        #1;
        mr = !r && !f && (q.size() < DEPTH);
        ga = 1'b0; gm = 1'b0;
        if (!r && !f) begin
            if (av && (q.size() == 0 || last_was_mem)) ga = 1'b1;
            else if (q.size() != 0)                    gm = 1'b1;
        end
        acc = mv && mr;
        chk("alu_ready", 32'(alu_ready), 32'(ga));
        chk("mem_ready", 32'(mem_ready), 32'(mr));
        @(posedge clk);
        if (r || f) begin
            q.delete();
            last_was_mem = 1'b1;
            e_y1c = '0; e_y1d = '0; e_y2c = '0; e_y2d = '0;
        end else begin
            if (ga) begin
                e_y1c = a1c; e_y1d = a1d; e_y2c = a2c; e_y2d = a2d;
                last_was_mem = 1'b0;
            end else if (gm) begin
                h = q.pop_front();
                e_y1c = h.ch; e_y1d = h.d; e_y2c = '0; e_y2d = '0;
                last_was_mem = 1'b1;
            end else begin
                e_y1c = '0; e_y1d = '0; e_y2c = '0; e_y2d = '0;
            end
            if (acc) q.push_back({mc, md});
        end
        @(negedge clk);
        chk("wb_y1_channel", 32'(wb_y1_channel), 32'(e_y1c));
        chk("wb_y1_data",    wb_y1_data,         e_y1d);
        chk("wb_y2_channel", 32'(wb_y2_channel), 32'(e_y2c));
        chk("wb_y2_data",    wb_y2_data,         e_y2d);
        chk("fifo_count",    32'(fifo_count),    32'(q.size()));
    endtask

    initial begin
        bit          ga, acc;
        logic [31:0] seq [6];
        logic [3:0]  lsu_ch [3];
        logic [31:0] alu_d;
        bit          p_av, p_mv;
        logic [3:0]  p_a1c, p_mc;
        logic [1:0]  p_a2c;
        logic [31:0] p_a1d, p_a2d, p_md;

        rst = 1'b1; flush = 1'b0; alu_valid = 1'b0; mem_valid = 1'b0;
        alu_y1_ch = '0; alu_y1_data = '0; alu_y2_ch = '0; alu_y2_data = '0;
        mem_y1_ch = '0; mem_y1_data = '0;
        @(negedge clk);

        // Reset held two cycles with both requesters active: nothing granted.
        step(1, 0, 1, 4'd3, 32'h11, 2'd1, 32'h22, 1, 4'd5, 32'h33, ga, acc);
        step(1, 0, 1, 4'd3, 32'h11, 2'd1, 32'h22, 1, 4'd5, 32'h33, ga, acc);
        chk("rst_fifo_count", 32'(fifo_count), 32'd0);
        chk("rst_wb_y1_data", wb_y1_data, 32'd0);

        // First tie after reset goes to ALU.
        step(0, 0, 0, 4'd0, 32'h0, 2'd0, 32'h0, 1, 4'd7, 32'h77, ga, acc);
        step(0, 0, 1, 4'd2, 32'hAA, 2'd0, 32'h0, 0, 4'd0, 32'h0, ga, acc);
        chk("first_tie_alu", 32'(wb_y1_channel), 32'd2);
        step(0, 0, 0, 4'd0, 32'h0, 2'd0, 32'h0, 0, 4'd0, 32'h0, ga, acc);
        chk("mem_after_tie", wb_y1_data, 32'h77);

        // ALU alone.
        step(0, 0, 1, 4'd3, 32'h1234, 2'd1, 32'h5, 0, 4'd0, 32'h0, ga, acc);
        chk("alu_alone_y1c", 32'(wb_y1_channel), 32'd3);
        chk("alu_alone_y1d", wb_y1_data, 32'h1234);
        chk("alu_alone_y2c", 32'(wb_y2_channel), 32'd1);
        chk("alu_alone_y2d", wb_y2_data, 32'h5);

        // Contention: ALU always valid, three loads back-to-back.
        step(1, 0, 0, 4'd0, 32'h0, 2'd0, 32'h0, 0, 4'd0, 32'h0, ga, acc);
        seq[0] = 32'hA000_0000; seq[1] = 32'hB000_0001; seq[2] = 32'hA000_0001;
        seq[3] = 32'hB000_0002; seq[4] = 32'hA000_0002; seq[5] = 32'hB000_0004;
        lsu_ch[0] = 4'd1; lsu_ch[1] = 4'd2; lsu_ch[2] = 4'd4;
        alu_d = 32'hA000_0000;
        for (int k = 0; k < 6; k++) begin
            if (k < 3)
                step(0, 0, 1, 4'd6, alu_d, 2'd2, 32'h9, 1, lsu_ch[k], 32'hB000_0000 | 32'(lsu_ch[k]), ga, acc);
            else
                step(0, 0, 1, 4'd6, alu_d, 2'd2, 32'h9, 0, 4'd0, 32'h0, ga, acc);
            if (ga) alu_d = alu_d + 1;
            chk($sformatf("contend_%0d", k), wb_y1_data, seq[k]);
        end

        // Fill the FIFO while ALU keeps competing.
        step(1, 0, 0, 4'd0, 32'h0, 2'd0, 32'h0, 0, 4'd0, 32'h0, ga, acc);
        for (int k = 0; k < 7; k++)
            step(0, 0, 1, 4'd1, 32'h100 + k, 2'd0, 32'h0, 1, 4'd9, 32'h200 + k, ga, acc);
        chk("full_count", 32'(fifo_count), 32'd4);
        chk("full_mem_ready", 32'(mem_ready), 32'd0);
        step(0, 0, 1, 4'd1, 32'h107, 2'd0, 32'h0, 1, 4'd9, 32'h207, ga, acc);
        chk("full_refused", 32'(acc), 32'd0);
        chk("after_pop_count", 32'(fifo_count), 32'd3);

        // Flush with three queued entries.
        step(0, 1, 1, 4'd1, 32'h108, 2'd0, 32'h0, 1, 4'd9, 32'h208, ga, acc);
        chk("flush_count", 32'(fifo_count), 32'd0);
        chk("flush_wb", 32'(wb_y1_channel), 32'd0);
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 0, 4'd0, 32'h0, 2'd0, 32'h0, 0, 4'd0, 32'h0, ga, acc);
            chk("post_flush_idle", wb_y1_data, 32'd0);
        end

        // Randomized traffic; requesters hold their offer until taken.
        p_av = 0; p_mv = 0;
        p_a1c = '0; p_a1d = '0; p_a2c = '0; p_a2d = '0; p_mc = '0; p_md = '0;
        for (int n = 0; n < 3000; n++) begin
            if (!p_av) begin
                p_av  = ($urandom_range(0, 99) < 60);
                p_a1c = 4'($urandom); p_a1d = $urandom;
                p_a2c = 2'($urandom); p_a2d = $urandom;
            end
            if (!p_mv) begin
                p_mv = ($urandom_range(0, 99) < 70);
                p_mc = 4'($urandom); p_md = $urandom;
            end
            step($urandom_range(0, 199) == 0, $urandom_range(0, 59) == 0,
                 p_av, p_a1c, p_a1d, p_a2c, p_a2d, p_mv, p_mc, p_md, ga, acc);
            if (ga)  p_av = 0;
            if (acc) p_mv = 0;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
